// File: rtl/pong_pkg.sv
// Shared constants and state types for the UART packet transmit path.
package pong_pkg;

  localparam int   MAX_PAYLD_PKT_BITS = 56;
  localparam int   HDR_MODE_BIT       = 7;
  localparam int   HDR_LEN_LSB        = 0;
  localparam int   HDR_LEN_MSB        = 2;
  localparam logic UART_IDLE_LVL      = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_DONE
  } tx_state_t;

  typedef enum logic [1:0] {
    PKT_IDLE,
    PKT_SEND,
    PKT_DONE
  } pkt_state_t;

endpackage

// File: rtl/uart_pkt_tx_if.sv
// Request/status bundle between the packet source and the UART packet transmitter.
interface uart_pkt_tx_if #(
  parameter int MAX_PAYLD_PKT_BITS = 56,
  parameter int SETUP_BITS         = 31
);
  logic [SETUP_BITS-1:0]         i_setup;
  logic                          i_valid;
  logic                          o_ready;
  logic                          i_is_prog_mode;
  logic [2:0]                    i_len_bytes;
  logic [MAX_PAYLD_PKT_BITS-1:0] i_payload;
  logic                          o_busy;
  logic                          o_done;
  logic                          o_uart_tx;

  modport master (
    output i_setup, i_valid, i_is_prog_mode, i_len_bytes, i_payload,
    input  o_ready, o_busy, o_done, o_uart_tx
  );

  modport slave (
    input  i_setup, i_valid, i_is_prog_mode, i_len_bytes, i_payload,
    output o_ready, o_busy, o_done, o_uart_tx
  );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 single-byte serializer; a start request during the last stop-bit clock
// chains the next frame with no idle gap.
module uart_tx_byte
  import pong_pkg::*;
#(
  parameter int SETUP_BITS = 31
) (
  input  logic                  i_clk,
  input  logic                  n_btn_rst,
  input  logic                  i_start,
  input  logic [7:0]            i_byte,
  input  logic [SETUP_BITS-1:0] i_div,
  output logic                  o_tx,
  output logic                  o_byte_done
);

  tx_state_t             state_q, state_d;
  logic [SETUP_BITS-1:0] cnt_q, cnt_d;
  logic [SETUP_BITS-1:0] div_q, div_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            sh_q, sh_d;
  logic                  tx_q, tx_d;
  logic                  last;
  logic                  load;

  assign last        = (cnt_q == div_q - SETUP_BITS'(1));
  assign o_byte_done = (state_q == TX_STOP) && last;
  assign load        = i_start && ((state_q == TX_IDLE) || o_byte_done);
  assign o_tx        = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = last ? '0 : cnt_q + SETUP_BITS'(1);
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    case (state_q)
      TX_START: begin
        if (last) begin
          state_d = TX_DATA;
          bit_d   = '0;
          tx_d    = sh_q[0];
        end
      end
      TX_DATA: begin
        if (last) begin
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = UART_IDLE_LVL;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end
      end
      TX_STOP: begin
        if (last) state_d = TX_IDLE;
      end
      default: begin
        state_d = TX_IDLE;
        cnt_d   = '0;
        tx_d    = UART_IDLE_LVL;
      end
    endcase
    // A new byte overrides whatever the phase logic above decided.
    if (load) begin
      state_d = TX_START;
      cnt_d   = '0;
      div_d   = i_div;
      bit_d   = '0;
      sh_d    = i_byte;
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge n_btn_rst) begin
    if (!n_btn_rst) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= UART_IDLE_LVL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_pkt_tx.sv
// Packet sequencer: sends a header byte then up to MAXB payload bytes as
// back-to-back 8N1 frames through uart_tx_byte.
module uart_pkt_tx #(
  parameter int MAX_PAYLD_PKT_BITS = pong_pkg::MAX_PAYLD_PKT_BITS,
  parameter int SETUP_BITS         = 31
) (
  input  logic         i_clk,
  input  logic         n_btn_rst,
  uart_pkt_tx_if.slave bus
);
  import pong_pkg::*;

  localparam int MAXB = MAX_PAYLD_PKT_BITS / 8;

  function automatic logic [SETUP_BITS-1:0] clamp_div(input logic [SETUP_BITS-1:0] s);
    return (s < SETUP_BITS'(2)) ? SETUP_BITS'(2) : s;
  endfunction

  function automatic logic [2:0] clamp_len(input logic [2:0] l);
    return (int'(l) > MAXB) ? 3'(MAXB) : l;
  endfunction

  function automatic logic [7:0] make_hdr(input logic prog, input logic [2:0] len);
    logic [7:0] h;
    h = '0;
    h[HDR_MODE_BIT]            = prog;
    h[HDR_LEN_MSB:HDR_LEN_LSB] = len;
    return h;
  endfunction

  pkt_state_t                    state_q, state_d;
  logic [2:0]                    len_q, len_d;
  logic [2:0]                    idx_q, idx_d;
  logic [MAX_PAYLD_PKT_BITS-1:0] pay_q, pay_d;
  logic [SETUP_BITS-1:0]         div_q, div_d;
  logic                          accept;
  logic                          byte_start;
  logic [7:0]                    byte_sel;
  logic [SETUP_BITS-1:0]         div_sel;
  logic                          byte_done;
  logic                          tx_line;

  assign accept = ((state_q == PKT_IDLE) || (state_q == PKT_DONE)) && bus.i_valid;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    pay_d      = pay_q;
    div_d      = div_q;
    byte_start = 1'b0;
    byte_sel   = pay_q[MAX_PAYLD_PKT_BITS-1 -: 8];
    div_sel    = div_q;
    case (state_q)
      PKT_SEND: begin
        if (byte_done) begin
          // idx counts payload bytes already started; compare before increment.
          if (idx_q == len_q) begin
            state_d = PKT_DONE;
          end else begin
            byte_start = 1'b1;
            idx_d      = idx_q + 3'd1;
            pay_d      = pay_q << 8;
          end
        end
      end
      default: begin
        state_d = PKT_IDLE;
        if (accept) begin
          state_d    = PKT_SEND;
          len_d      = clamp_len(bus.i_len_bytes);
          idx_d      = '0;
          pay_d      = bus.i_payload;
          div_d      = clamp_div(bus.i_setup);
          byte_start = 1'b1;
          byte_sel   = make_hdr(bus.i_is_prog_mode, clamp_len(bus.i_len_bytes));
          div_sel    = clamp_div(bus.i_setup);
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge n_btn_rst) begin
    if (!n_btn_rst) begin
      state_q <= PKT_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      pay_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      pay_q   <= pay_d;
      div_q   <= div_d;
    end
  end

  uart_tx_byte #(
    .SETUP_BITS(SETUP_BITS)
  ) u_byte (
    .i_clk      (i_clk),
    .n_btn_rst  (n_btn_rst),
    .i_start    (byte_start),
    .i_byte     (byte_sel),
    .i_div      (div_sel),
    .o_tx       (tx_line),
    .o_byte_done(byte_done)
  );

  assign bus.o_ready   = (state_q == PKT_IDLE) || (state_q == PKT_DONE);
  assign bus.o_busy    = (state_q == PKT_SEND);
  assign bus.o_done    = (state_q == PKT_DONE);
  assign bus.o_uart_tx = tx_line;

endmodule

// File: tb/tb_uart_pkt_tx.sv
// Directed bench for uart_pkt_tx: per-cycle line capture decoded as 8N1 frames.
module tb_uart_pkt_tx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_pkt_tx_if #(.MAX_PAYLD_PKT_BITS(56), .SETUP_BITS(31)) bus ();

  uart_pkt_tx #(.MAX_PAYLD_PKT_BITS(56), .SETUP_BITS(31)) dut (
    .i_clk    (clk),
    .n_btn_rst(rst_n),
    .bus      (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic       line_log[4096];
  logic       done_log[4096];
  logic       rdy_log[4096];
  logic       busy_log[4096];
  logic [7:0] rx_bytes[8];

  // Index 0 is sampled just after the accept edge; index k is k edges later.
  task automatic capture(input int n, input int drop_at);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k == drop_at) bus.i_valid = 1'b0;
      line_log[k] = bus.o_uart_tx;
      done_log[k] = bus.o_done;
      rdy_log[k]  = bus.o_ready;
      busy_log[k] = bus.o_busy;
    end
  endtask

  task automatic launch(input logic [30:0] setup, input logic prog, input logic [2:0] len,
                        input logic [55:0] pay, input bit hold);
    int w;
    bus.i_setup        = setup;
    bus.i_is_prog_mode = prog;
    bus.i_len_bytes    = len;
    bus.i_payload      = pay;
    bus.i_valid        = 1'b1;
    w = 0;
    while (bus.o_ready !== 1'b1 && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (bus.o_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL launch_ready_timeout got=%b want=1", bus.o_ready);
    end
    @(posedge clk);
    #1;
    if (!hold) bus.i_valid = 1'b0;
  endtask

  task automatic decode(input int base, input int d, input int nbytes,
                        output int glitch, output int ferr);
    glitch = 0;
    ferr   = 0;
    for (int n = 0; n < nbytes; n++) begin
      for (int b = 0; b < 10; b++) begin
        int   s;
        logic v;
        s = base + (n * 10 + b) * d;
        v = line_log[s];
        for (int c = 1; c < d; c++) if (line_log[s + c] !== v) glitch++;
        if (b == 0 && v !== 1'b0) ferr++;
        if (b == 9 && v !== 1'b1) ferr++;
        if (b >= 1 && b <= 8) rx_bytes[n][b - 1] = v;
      end
    end
  endtask

  function automatic int count_done(input int lo, input int hi);
    int c;
    c = 0;
    for (int k = lo; k <= hi; k++) if (done_log[k] === 1'b1) c++;
    return c;
  endfunction

  task automatic test_reset();
    n_tests++; if (bus.o_uart_tx !== 1'b1) begin n_fail++; $display("FAIL rst_line got=%b want=1", bus.o_uart_tx); end
    n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b want=1", bus.o_ready); end
    n_tests++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b want=0", bus.o_busy); end
    n_tests++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b want=0", bus.o_done); end
  endtask

  task automatic test_header_only();
    int g, f;
    launch(31'd4, 1'b1, 3'd0, 56'h0, 1'b0);
    capture(42, -1);
    decode(0, 4, 1, g, f);
    n_tests++; if (rx_bytes[0] !== 8'h80) begin n_fail++; $display("FAIL hdr0_byte got=%h want=80", rx_bytes[0]); end
    n_tests++; if (g != 0 || f != 0) begin n_fail++; $display("FAIL hdr0_frame glitch=%0d ferr=%0d want=0,0", g, f); end
    n_tests++; if (busy_log[0] !== 1'b1 || rdy_log[0] !== 1'b0) begin n_fail++; $display("FAIL hdr0_busy got=%b/%b want=1/0", busy_log[0], rdy_log[0]); end
    n_tests++; if (done_log[40] !== 1'b1 || rdy_log[40] !== 1'b1) begin n_fail++; $display("FAIL hdr0_done40 got=%b/%b want=1/1", done_log[40], rdy_log[40]); end
    n_tests++; if (count_done(0, 41) != 1) begin n_fail++; $display("FAIL hdr0_done_cnt got=%0d want=1", count_done(0, 41)); end
    n_tests++; if (busy_log[40] !== 1'b0 || line_log[40] !== 1'b1) begin n_fail++; $display("FAIL hdr0_idle got=%b/%b want=0/1", busy_log[40], line_log[40]); end
  endtask

  task automatic test_two_payload();
    int g, f;
    launch(31'd60, 1'b0, 3'd2, 56'hA53C_0000_0000_00, 1'b0);
    capture(1802, -1);
    decode(0, 60, 3, g, f);
    n_tests++; if (rx_bytes[0] !== 8'h02 || rx_bytes[1] !== 8'hA5 || rx_bytes[2] !== 8'h3C) begin
      n_fail++; $display("FAIL p2_bytes got=%h %h %h want=02 a5 3c", rx_bytes[0], rx_bytes[1], rx_bytes[2]); end
    n_tests++; if (g != 0 || f != 0) begin n_fail++; $display("FAIL p2_frame glitch=%0d ferr=%0d want=0,0", g, f); end
    n_tests++; if (done_log[1800] !== 1'b1 || done_log[1799] !== 1'b0) begin
      n_fail++; $display("FAIL p2_done got=%b@1800 %b@1799 want=1,0", done_log[1800], done_log[1799]); end
  endtask

  task automatic test_lengths();
    int g, f, bad;
    logic [7:0] exp7[8];
    logic [7:0] exp5[6];
    exp7 = '{8'h07, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    exp5 = '{8'h85, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    launch(31'd2, 1'b0, 3'd7, 56'h11_22_33_44_55_66_77, 1'b0);
    capture(162, -1);
    decode(0, 2, 8, g, f);
    bad = g + f;
    for (int i = 0; i < 8; i++) if (rx_bytes[i] !== exp7[i]) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL len7_bytes errors=%0d want=0", bad); end
    n_tests++; if (rx_bytes[7] !== 8'h77) begin n_fail++; $display("FAIL len7_last got=%h want=77", rx_bytes[7]); end
    n_tests++; if (done_log[160] !== 1'b1 || count_done(0, 161) != 1) begin
      n_fail++; $display("FAIL len7_done got=%b cnt=%0d want=1,1", done_log[160], count_done(0, 161)); end
    launch(31'd2, 1'b1, 3'd5, 56'h11_22_33_44_55_66_77, 1'b0);
    capture(122, -1);
    decode(0, 2, 6, g, f);
    bad = g + f;
    for (int i = 0; i < 6; i++) if (rx_bytes[i] !== exp5[i]) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL len5_bytes errors=%0d want=0", bad); end
    n_tests++; if (done_log[120] !== 1'b1 || count_done(0, 121) != 1) begin
      n_fail++; $display("FAIL len5_done got=%b cnt=%0d want=1,1", done_log[120], count_done(0, 121)); end
  endtask

  task automatic test_div_clamp();
    logic [9:0] frame;
    int bad;
    frame = 10'b11_0000_0000;
    for (int s = 0; s < 2; s++) begin
      launch(31'(s), 1'b1, 3'd0, 56'h0, 1'b0);
      capture(22, -1);
      bad = 0;
      for (int k = 0; k < 20; k++) if (line_log[k] !== frame[k / 2]) bad++;
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL div%0d_pattern errors=%0d want=0", s, bad); end
      n_tests++; if (done_log[20] !== 1'b1 || count_done(0, 21) != 1) begin
        n_fail++; $display("FAIL div%0d_done got=%b cnt=%0d want=1,1", s, done_log[20], count_done(0, 21)); end
    end
  endtask

  task automatic test_back_to_back();
    int g, f;
    launch(31'd3, 1'b0, 3'd1, 56'hC3_0000_0000_0000, 1'b1);
    for (int k = 0; k < 164; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k == 10) begin
        bus.i_payload      = 56'hFF_0000_0000_0000;
        bus.i_is_prog_mode = 1'b1;
        bus.i_setup        = 31'd5;
      end
      if (k == 70) bus.i_valid = 1'b0;
      line_log[k] = bus.o_uart_tx;
      done_log[k] = bus.o_done;
    end
    decode(0, 3, 2, g, f);
    n_tests++; if (rx_bytes[0] !== 8'h01 || rx_bytes[1] !== 8'hC3 || g != 0 || f != 0) begin
      n_fail++; $display("FAIL b2b_first got=%h %h g=%0d f=%0d want=01 c3", rx_bytes[0], rx_bytes[1], g, f); end
    n_tests++; if (done_log[60] !== 1'b1 || line_log[60] !== 1'b1 || line_log[61] !== 1'b0) begin
      n_fail++; $display("FAIL b2b_turn got=%b %b %b want=1 1 0", done_log[60], line_log[60], line_log[61]); end
    decode(61, 5, 2, g, f);
    n_tests++; if (rx_bytes[0] !== 8'h81 || rx_bytes[1] !== 8'hFF || g != 0 || f != 0) begin
      n_fail++; $display("FAIL b2b_second got=%h %h g=%0d f=%0d want=81 ff", rx_bytes[0], rx_bytes[1], g, f); end
    n_tests++; if (done_log[161] !== 1'b1 || count_done(0, 163) != 2) begin
      n_fail++; $display("FAIL b2b_done got=%b cnt=%0d want=1,2", done_log[161], count_done(0, 163)); end
  endtask

  task automatic test_reset_mid();
    int g, f, hi;
    launch(31'd4, 1'b0, 3'd2, 56'hA5F0_0000_0000_00, 1'b0);
    capture(58, -1);
    n_tests++; if (line_log[57] !== 1'b0) begin n_fail++; $display("FAIL rmid_pre got=%b want=0", line_log[57]); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.o_uart_tx !== 1'b1 || bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async got=%b %b %b want=1 1 0", bus.o_uart_tx, bus.o_ready, bus.o_busy); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    capture(60, -1);
    hi = 0;
    for (int k = 0; k < 60; k++) if (line_log[k] === 1'b1 && done_log[k] === 1'b0) hi++;
    n_tests++; if (hi != 60) begin n_fail++; $display("FAIL rmid_quiet got=%0d want=60", hi); end
    launch(31'd2, 1'b1, 3'd1, 56'h3C_0000_0000_0000, 1'b0);
    capture(42, -1);
    decode(0, 2, 2, g, f);
    n_tests++; if (rx_bytes[0] !== 8'h81 || rx_bytes[1] !== 8'h3C || g != 0 || f != 0) begin
      n_fail++; $display("FAIL rmid_after got=%h %h g=%0d f=%0d want=81 3c", rx_bytes[0], rx_bytes[1], g, f); end
    n_tests++; if (done_log[40] !== 1'b1) begin n_fail++; $display("FAIL rmid_done got=%b want=1", done_log[40]); end
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.i_setup        = '0;
    bus.i_valid        = 1'b0;
    bus.i_is_prog_mode = 1'b0;
    bus.i_len_bytes    = '0;
    bus.i_payload      = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_header_only();
    test_two_payload();
    test_lengths();
    test_div_clamp();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_pkt_tx.md
Name: uart_pkt_tx

Overview:
- Response-side counterpart to the UART packet receive path: serializes one packet (header byte plus 0..7 payload bytes) onto o_uart_tx as 8N1 UART frames.
- Runs in the pixel-clock domain.
- Fed by CommandBuffer/render control logic to echo status or acks to the host.
- Baud timing uses the same i_setup clock-divider convention as the receive path (baud = i_clk / i_setup).

Parameters:
- MAX_PAYLD_PKT_BITS, 56, width of i_payload; must be a multiple of 8; max bytes MAXB = MAX_PAYLD_PKT_BITS/8.
- SETUP_BITS, 31, width of the i_setup divider input.

Ports:
- i_clk  in  1  pixel clock; sole clock.
- n_btn_rst  in  1  asynchronous, active-low reset.
- i_setup  in  SETUP_BITS  clocks per UART bit; sampled at packet accept.
- i_valid  in  1  packet request.
- o_ready  out  1  block can accept a packet this cycle.
- i_is_prog_mode  in  1  mode flag placed in the header.
- i_len_bytes  in  3  number of payload bytes to send (0..MAXB).
- i_payload  in  MAX_PAYLD_PKT_BITS  payload, first byte in the MSBs.
- o_busy  out  1  frame transmission in progress.
- o_done  out  1  one-cycle pulse when the last stop bit completes.
- o_uart_tx  out  1  UART line; idles high.

Behaviour:
- Reset (async assert, sync release): o_uart_tx=1, o_ready=1, o_busy=0, o_done=0, state=IDLE. All counters clear.
- Reset mid-frame: line returns high immediately and the packet is dropped. No o_done.
- Accept: i_valid && o_ready on a rising edge. At accept, latch i_setup, i_is_prog_mode, len, and i_payload. Then o_ready=0 and o_busy=1 from the next cycle.
- Inputs are ignored while busy. i_valid while o_ready=0 is neither queued nor an error.
- Length clamp: len = min(i_len_bytes, MAXB).
- Divider clamp: effective divider D = max(i_setup, 2).
- Header byte: bit7 = is_prog_mode; bits6:3 = 0; bits2:0 = len.
- Byte order: header first, then payload byte k (k=0..len-1) = payload[MAX_PAYLD_PKT_BITS-1-8k -: 8].
- Each byte is sent as: start(0), data LSB-first (8 bits), stop(1). Each bit lasts exactly D clocks.
- Frames are back-to-back with no idle gap between bytes.
- FSM states:
  - IDLE: o_ready=1. On accept, go to START.
  - START: o_uart_tx=0 for D clocks, then DATA.
  - DATA: bit index 0..7, each held D clocks. After bit 7, go to STOP.
  - STOP: o_uart_tx=1 for D clocks. If bytes remain, go to START with the next byte; else go to DONE.
  - DONE: o_done=1 for one cycle, o_busy=0, o_ready=1. Next state is IDLE. A new accept is legal in this cycle and goes straight to START.
- o_uart_tx is registered. The start bit appears on the cycle after accept.
- Total time from accept to o_done = (1+len)*10*D clocks.
- Baud counter counts 0..D-1, is SETUP_BITS wide, and rolls over with no wrap hazard because D ≤ 2^SETUP_BITS-1.
- Byte counter is 3 bits and counts header + len ≤ 8 bytes; the terminal value is compared before increment so there is no wrap.
- No combinational path from any input to o_uart_tx.

Decomposition:
- Shared package pong_pkg holds:
  - MAX_PAYLD_PKT_BITS.
  - Header field positions: HDR_MODE_BIT=7 and HDR_LEN lsb/msb.
  - UART_IDLE_LVL=1.
  - State enum typedef tx_state_t.
- Sub-module uart_tx_byte: an 8N1 single-byte serializer with i_start, i_byte, i_div, o_tx, o_byte_done.
- The top FSM handles packet sequencing and byte selection only.

Test Plan:
- D=4, prog=1, len=0 -> one frame with header 0x80: line pattern 0,0,0,0,0,0,0,1 then stop, 40 clocks. o_done pulses at clock 40; o_ready=1 at the same cycle.
- D=60, prog=0, len=2, payload=0xA5_3C_000000_0000 -> bytes 0x02,0xA5,0x3C. Decode with the existing receive path and match; o_done at 1800 clocks.
- len=7 and i_len_bytes=5 with D=2 -> 8 and 6 bytes respectively. The last byte of len=7 = payload[7:0].
- i_setup=0 and i_setup=1 -> each bit held exactly 2 clocks.
- i_valid held high through a frame with i_payload changed mid-frame -> transmitted bytes match the value latched at accept. A second packet starts on the DONE-cycle accept with no idle bit.
- Assert n_btn_rst during DATA bit 3 of byte 1 -> o_uart_tx=1 asynchronously, no o_done. After release, o_ready=1 and a new packet transmits correctly.
